// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared constants and pointer helper for the return address stack
package processor_pkg;

    // Default width of the PC and of every stored return address.
    localparam int ADDR_WIDTH_DEFAULT = 12;

    // Overflow policies.
    localparam int OVF_REFUSE   = 0;
    localparam int OVF_CIRCULAR = 1;

    // Modulo-depth step with an explicit wrap, so that depth does not have to be a power of two.
    // up=1 increments the pointer; up=0 decrements it.
    function automatic int unsigned ptr_step(input int unsigned ptr,
                                             input int unsigned depth,
                                             input bit          up);
        if (up)
            return (ptr >= depth - 1) ? 0 : ptr + 1;
        else
            return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/stack_pointer_ctrl.sv
// rtl/stack_pointer_ctrl.sv - top pointer, occupancy and push/pop/replace decode
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   push_req, pop_req      call / return requests, sampled every edge
//   wr_en, wr_idx          storage write strobe and slot to write
//   rd_idx                 slot holding the current top entry
//   depth_count            entries held, 0..DEPTH
//   full, empty            decodes of depth_count
module stack_pointer_ctrl
    import processor_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int OVERFLOW_MODE = OVF_REFUSE,
    parameter int PW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_req,
    input  logic          pop_req,
    output logic          wr_en,
    output logic [PW-1:0] wr_idx,
    output logic [PW-1:0] rd_idx,
    output logic [CW-1:0] depth_count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] tp;
    logic [PW-1:0] tp_nxt;
    logic [PW-1:0] tp_inc;
    logic [CW-1:0] count_nxt;
    logic          push_eff;

    assign full   = (depth_count == CW'(DEPTH));
    assign empty  = (depth_count == '0);
    assign tp_inc = PW'(ptr_step(32'(tp), DEPTH, 1'b1));
    assign rd_idx = PW'(ptr_step(32'(tp), DEPTH, 1'b0));

    // A call together with a return on an empty stack degenerates to a plain push.
    assign push_eff = push_req && (!pop_req || empty);

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = tp;
        tp_nxt    = tp;
        count_nxt = depth_count;
        if (push_req && pop_req && !empty) begin
            // Tail call: overwrite the top entry in place.
            wr_en  = 1'b1;
            wr_idx = rd_idx;
        end else if (push_eff) begin
            if (!full) begin
                wr_en     = 1'b1;
                tp_nxt    = tp_inc;
                count_nxt = depth_count + 1'b1;
            end else if (OVERFLOW_MODE == OVF_CIRCULAR) begin
                // When full, tp points at the oldest entry; it is the one sacrificed.
                wr_en  = 1'b1;
                tp_nxt = tp_inc;
            end
        end else if (pop_req && !push_req && !empty) begin
            tp_nxt    = rd_idx;
            count_nxt = depth_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tp          <= '0;
            depth_count <= '0;
        end else begin
            tp          <= tp_nxt;
            depth_count <= count_nxt;
        end
    end

endmodule

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - parametrised return address stack for nested CALL/RTS
//
// Ports:
//   clock, reset                         rising-edge clock, synchronous active-high reset
//   subroutine_call, subroutine_return   push / pop requests, one operation per sampled edge
//   PC                                   current PC; PC+RETURN_OFFSET is pushed
//   clear_errors                         clears the sticky flags (a same-cycle error wins)
//   RTS_adr                              top of stack, 0 when empty, valid in the pop cycle
//   depth_count, full, empty             occupancy status
//   overflow, underflow                  sticky error flags
module return_address_stack
    import processor_pkg::*;
#(
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEFAULT,
    parameter int DEPTH         = 8,
    parameter int RETURN_OFFSET = 0,
    parameter int OVERFLOW_MODE = OVF_REFUSE,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  subroutine_call,
    input  logic                  subroutine_return,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  clear_errors,
    output logic [ADDR_WIDTH-1:0] RTS_adr,
    output logic [CW-1:0]         depth_count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] push_value;
    logic                  wr_en;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx;
    logic                  overflow_evt;
    logic                  underflow_evt;

    stack_pointer_ctrl #(
        .DEPTH         (DEPTH),
        .OVERFLOW_MODE (OVERFLOW_MODE),
        .PW            (PW),
        .CW            (CW)
    ) u_ptr (
        .clock       (clock),
        .reset       (reset),
        .push_req    (subroutine_call),
        .pop_req     (subroutine_return),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .rd_idx      (rd_idx),
        .depth_count (depth_count),
        .full        (full),
        .empty       (empty)
    );

    // Truncating add: the return address wraps modulo 2^ADDR_WIDTH.
    assign push_value = PC + ADDR_WIDTH'(RETURN_OFFSET);

    // Storage needs no reset; empty masks stale contents on the read port.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_idx] <= push_value;
    end

    assign RTS_adr = empty ? '0 : mem[rd_idx];

    // A tail call is never an error, even on a full or empty stack.
    assign overflow_evt  = subroutine_call && !subroutine_return && full;
    assign underflow_evt = subroutine_return && !subroutine_call && empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow_evt  || (overflow  && !clear_errors);
            underflow <= underflow_evt || (underflow && !clear_errors);
        end
    end

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - scoreboard bench for return_address_stack
module tb_return_address_stack;

    logic        clock = 1'b0;
    logic        reset;
    logic        subroutine_call;
    logic        subroutine_return;
    logic [11:0] PC;
    logic        clear_errors;

    logic [11:0] rts0, rts1, rts2, rts3;
    logic [3:0]  cnt0, cnt1;
    logic [2:0]  cnt2, cnt3;
    logic [3:0]  full_v, empty_v, ovf_v, unf_v;

    always #5 clock = ~clock;

    // u0: DEPTH 8 offset 0; u1: DEPTH 8 offset 1; u2: DEPTH 4 refuse; u3: DEPTH 4 circular
    return_address_stack #(.ADDR_WIDTH(12), .DEPTH(8), .RETURN_OFFSET(0), .OVERFLOW_MODE(0)) u0 (
        .clock(clock), .reset(reset), .subroutine_call(subroutine_call),
        .subroutine_return(subroutine_return), .PC(PC), .clear_errors(clear_errors),
        .RTS_adr(rts0), .depth_count(cnt0), .full(full_v[0]), .empty(empty_v[0]),
        .overflow(ovf_v[0]), .underflow(unf_v[0]));
    return_address_stack #(.ADDR_WIDTH(12), .DEPTH(8), .RETURN_OFFSET(1), .OVERFLOW_MODE(0)) u1 (
        .clock(clock), .reset(reset), .subroutine_call(subroutine_call),
        .subroutine_return(subroutine_return), .PC(PC), .clear_errors(clear_errors),
        .RTS_adr(rts1), .depth_count(cnt1), .full(full_v[1]), .empty(empty_v[1]),
        .overflow(ovf_v[1]), .underflow(unf_v[1]));
    return_address_stack #(.ADDR_WIDTH(12), .DEPTH(4), .RETURN_OFFSET(0), .OVERFLOW_MODE(0)) u2 (
        .clock(clock), .reset(reset), .subroutine_call(subroutine_call),
        .subroutine_return(subroutine_return), .PC(PC), .clear_errors(clear_errors),
        .RTS_adr(rts2), .depth_count(cnt2), .full(full_v[2]), .empty(empty_v[2]),
        .overflow(ovf_v[2]), .underflow(unf_v[2]));
    return_address_stack #(.ADDR_WIDTH(12), .DEPTH(4), .RETURN_OFFSET(0), .OVERFLOW_MODE(1)) u3 (
        .clock(clock), .reset(reset), .subroutine_call(subroutine_call),
        .subroutine_return(subroutine_return), .PC(PC), .clear_errors(clear_errors),
        .RTS_adr(rts3), .depth_count(cnt3), .full(full_v[3]), .empty(empty_v[3]),
        .overflow(ovf_v[3]), .underflow(unf_v[3]));

    typedef struct packed {
        logic [11:0] rts;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } obs_t;

    logic [1:0]  sel;
    obs_t        obs;
    obs_t        exp_q[$];
    logic [11:0] peek_q[$];
    int          vectors;
    int          miscompares;

    always_comb begin
        obs = '0;
        case (sel)
            2'd0: obs = '{rts0, cnt0, full_v[0], empty_v[0], ovf_v[0], unf_v[0]};
            2'd1: obs = '{rts1, cnt1, full_v[1], empty_v[1], ovf_v[1], unf_v[1]};
            2'd2: obs = '{rts2, {1'b0, cnt2}, full_v[2], empty_v[2], ovf_v[2], unf_v[2]};
            default: obs = '{rts3, {1'b0, cnt3}, full_v[3], empty_v[3], ovf_v[3], unf_v[3]};
        endcase
    end

    task automatic expect_state(input logic [11:0] rts, input logic [3:0] cnt,
                                input logic f, input logic e, input logic o, input logic u);
        obs_t x;
        x = '{rts, cnt, f, e, o, u};
        exp_q.push_back(x);
    endtask

    // One clock of stimulus; optional same-cycle check of RTS_adr, then post-edge scoreboard check.
    task automatic op(input string name, input logic c, input logic r, input logic [11:0] pc,
                      input logic clr, input logic rst, input logic peek);
        obs_t        e;
        logic [11:0] pv;
        @(negedge clock);
        subroutine_call   = c;
        subroutine_return = r;
        PC                = pc;
        clear_errors      = clr;
        reset             = rst;
        if (peek) begin
            #1;
            vectors++;
            if (peek_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s peek: no expected value queued", name);
            end else begin
                pv = peek_q.pop_front();
                if (obs.rts !== pv) begin
                    miscompares++;
                    $display("FAIL %s peek: RTS_adr=%0d expected %0d", name, obs.rts, pv);
                end
            end
        end
        @(posedge clock);
        #1;
        subroutine_call   = 1'b0;
        subroutine_return = 1'b0;
        clear_errors      = 1'b0;
        reset             = 1'b0;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no expected state queued", name);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e)
                begin
                    miscompares++;
                    $display("FAIL %s: got rts=%0d cnt=%0d f=%b e=%b ovf=%b unf=%b expected rts=%0d cnt=%0d f=%b e=%b ovf=%b unf=%b",
                             name, obs.rts, obs.cnt, obs.full, obs.empty, obs.ovf, obs.unf,
                             e.rts, e.cnt, e.full, e.empty, e.ovf, e.unf);
                end
        end
    endtask

    task automatic do_reset();
        expect_state(12'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        op("reset", 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            do_reset();
        end
    endtask

    task automatic test_nested();
        sel = 2'd0;
        do_reset();
        expect_state(12'd131, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op("nested_call1", 1'b1, 1'b0, 12'd131, 1'b0, 1'b0, 1'b0);
        expect_state(12'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op("nested_call2", 1'b1, 1'b0, 12'd5, 1'b0, 1'b0, 1'b0);
        peek_q.push_back(12'd5);
        expect_state(12'd131, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op("nested_ret1", 1'b0, 1'b1, 12'd102, 1'b0, 1'b0, 1'b1);
        peek_q.push_back(12'd131);
        expect_state(12'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        op("nested_ret2", 1'b0, 1'b1, 12'd103, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_offset();
        sel = 2'd1;
        do_reset();
        expect_state(12'd697, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op("offset_call", 1'b1, 1'b0, 12'd696, 1'b0, 1'b0, 1'b0);
        expect_state(12'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op("offset_wrap", 1'b1, 1'b0, 12'd4095, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) begin
            expect_state(12'(i * 10), 4'(i), (i == 4), 1'b0, 1'b0, 1'b0);
            op("fill", 1'b1, 1'b0, 12'(i * 10), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_full_refuse();
        sel = 2'd2;
        do_reset();
        fill4();
        expect_state(12'd40, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        op("refuse_push", 1'b1, 1'b0, 12'd50, 1'b0, 1'b0, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            peek_q.push_back(12'(i * 10));
            expect_state((i == 1) ? 12'd0 : 12'((i - 1) * 10), 4'(i - 1), 1'b0, (i == 1), 1'b1, 1'b0);
            op("refuse_pop", 1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_full_circular();
        sel = 2'd3;
        do_reset();
        fill4();
        expect_state(12'd50, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        op("circ_push", 1'b1, 1'b0, 12'd50, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i >= 2; i--) begin
            peek_q.push_back(12'(i * 10));
            expect_state((i == 2) ? 12'd0 : 12'((i - 1) * 10), 4'(i - 2), 1'b0, (i == 2), 1'b1, 1'b0);
            op("circ_pop", 1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_underflow();
        sel = 2'd0;
        do_reset();
        peek_q.push_back(12'd0);
        expect_state(12'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        op("underflow_pop", 1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1);
        expect_state(12'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        op("underflow_clear", 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
        expect_state(12'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        op("underflow_set_wins", 1'b0, 1'b1, 12'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_tail_and_reset();
        sel = 2'd0;
        do_reset();
        expect_state(12'd44, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op("tail_on_empty", 1'b1, 1'b1, 12'd44, 1'b0, 1'b0, 1'b0);
        do_reset();
        expect_state(12'd131, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op("tail_call1", 1'b1, 1'b0, 12'd131, 1'b0, 1'b0, 1'b0);
        expect_state(12'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op("tail_call2", 1'b1, 1'b0, 12'd5, 1'b0, 1'b0, 1'b0);
        expect_state(12'd333, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op("tail_replace", 1'b1, 1'b1, 12'd333, 1'b0, 1'b0, 1'b0);
        peek_q.push_back(12'd333);
        expect_state(12'd131, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op("tail_pop", 1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1);
        expect_state(12'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        op("reset_mid_nesting", 1'b1, 1'b0, 12'd77, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 2'd2;
        do_reset();
        fill4();
        expect_state(12'd99, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        op("tail_on_full", 1'b1, 1'b1, 12'd99, 1'b0, 1'b0, 1'b0);
        expect_state(12'd99, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        op("ovf_then", 1'b1, 1'b0, 12'd7, 1'b0, 1'b0, 1'b0);
        expect_state(12'd30, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        op("pop_with_clear", 1'b0, 1'b1, 12'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        sel               = 2'd0;
        reset             = 1'b1;
        subroutine_call   = 1'b0;
        subroutine_return = 1'b0;
        PC                = '0;
        clear_errors      = 1'b0;
        test_reset();
        test_nested();
        test_offset();
        test_full_refuse();
        test_full_circular();
        test_underflow();
        test_tail_and_reset();
        test_back_to_back();
        if (exp_q.size() != 0 || peek_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d states, %0d peeks still queued", exp_q.size(), peek_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Parametrised successor to the processor's fixed single-use subroutine stack.
- Holds up to DEPTH return addresses for nested CALL/RTS.
- Adds a configurable return offset, full/empty status, an occupancy count, and sticky overflow/underflow error flags.
- Adds selectable overflow policy (refuse or circular overwrite) and a defined simultaneous call+return (tail-call) behaviour.
- Sits beside the PC register; the control unit drives call/return, and the PC mux takes RTS_adr on return.

Parameters:
- ADDR_WIDTH, 12: width of PC and of the stored return addresses.
- DEPTH, 8: number of entries; any integer ≥ 2, power of two not required.
- RETURN_OFFSET, 0: constant added to PC on push, modulo 2^ADDR_WIDTH (0 = store PC as given, 1 = store PC+1).
- OVERFLOW_MODE, 0: 0 = refuse push when full; 1 = circular, overwrite oldest entry.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- subroutine_call  input  1  push request, sampled each rising edge.
- subroutine_return  input  1  pop request, sampled each rising edge.
- PC  input  ADDR_WIDTH  current PC; pushed value is PC+RETURN_OFFSET.
- clear_errors  input  1  synchronous clear of the sticky error flags.
- RTS_adr  output  ADDR_WIDTH  current top of stack; combinational from registered state; 0 when empty.
- depth_count  output  CW  entries held, 0..DEPTH, where CW = clog2(DEPTH+1).
- full  output  1  depth_count == DEPTH.
- empty  output  1  depth_count == 0.
- overflow  output  1  sticky; set by any push made while full.
- underflow  output  1  sticky; set by any pop made while empty.

Behaviour:
- Reset: depth_count=0, pointers=0, overflow=0, underflow=0, empty=1, full=0, RTS_adr=0. Storage contents need not be cleared.
- Reset wins over every other input in the same cycle, including mid-nesting; all entries are discarded.
- Storage is a DEPTH-entry register array.
  - Top pointer tp indexes the next free slot; top entry = mem[(tp-1) mod DEPTH].
  - Pointer arithmetic is modulo DEPTH, with explicit wrap; no power-of-two assumption.
- Zero-latency read: RTS_adr shows the top entry in the same cycle subroutine_return is asserted. The PC mux uses it that cycle; the pop commits at the edge.
- Push only (call=1, return=0):
  - Not full: mem[tp] <= PC+RETURN_OFFSET; tp++; count++.
  - Full, MODE 0: no state change; overflow<=1.
  - Full, MODE 1: write mem[tp]; tp++; count stays DEPTH; overflow<=1. The oldest entry is lost.
- Pop only (call=0, return=1):
  - Not empty: tp--; count--.
  - Empty: no state change; underflow<=1; RTS_adr stays 0.
- Simultaneous call and return (tail call):
  - Not empty: replace the top entry with PC+RETURN_OFFSET; tp and count unchanged; no flag set, even when full.
  - Empty: behaves as a plain push; no underflow.
- Neither request: hold.
- Levels are sampled every edge, so a request held high for N cycles is N operations. The control unit pulses each request for exactly one cycle.
- clear_errors=1 clears overflow and underflow at the edge. If a new error occurs in the same cycle, the set wins.
- full and empty are combinational decodes of depth_count and never glitch relative to the registered count.
- Addition PC+RETURN_OFFSET truncates to ADDR_WIDTH (wrap-around), e.g. 4095+1 -> 0 for ADDR_WIDTH 12.

Decomposition:
- Shared package processor_pkg holds:
  - the ADDR_WIDTH default (12);
  - localparams OVF_REFUSE=0 and OVF_CIRCULAR=1;
  - a function for modulo-DEPTH increment/decrement.
- One sub-module is natural: stack_pointer_ctrl. It owns tp, depth_count, full/empty and the push/pop/replace decode, emitting write-enable, write index and read index.
- The top level holds the storage array, the offset adder, and the sticky flags.

Test Plan:
- Nested pair (DEPTH 8, OFFSET 0):
  - call PC=131 -> RTS_adr=131, count=1.
  - call PC=5 -> RTS_adr=5, count=2.
  - return with PC=102 -> RTS_adr=5 visible in the pop cycle, then 131 after the edge, count=1.
  - return again -> RTS_adr=0, empty=1.
- Offset/wrap (OFFSET 1): call PC=696 -> RTS_adr=697; call PC=4095 -> RTS_adr=0, count=2.
- Full, MODE 0 (DEPTH 4): push 10,20,30,40 -> full=1. Push 50 -> overflow=1, RTS_adr=40, count=4. Four pops return 40,30,20,10.
- Full, MODE 1 (DEPTH 4): push 10..50 -> overflow=1, count=4. Pops return 50,40,30,20, then empty=1.
- Underflow and clear: return on empty -> underflow=1, RTS_adr=0, count=0. clear_errors pulse -> underflow=0. Pop-on-empty together with clear_errors in the same cycle -> underflow stays 1.
- Tail call and reset:
  - Stack {131,5}; call+return with PC=333 -> RTS_adr=333, count=2.
  - Then reset mid-nesting -> count=0, empty=1, RTS_adr=0, overflow=0, underflow=0.
